// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: FSM states, default geometry and sample-point helpers for uart_rx_frame
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;
  function automatic int mid_tick(input int os);
    return os / 2 - 1;
  endfunction
  function automatic int last_tick(input int os);
    return os - 1;
  endfunction
  localparam int MID_TICK  = mid_tick(OVERSAMPLE_DEF);
  localparam int LAST_TICK = last_tick(OVERSAMPLE_DEF);
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF rx_line synchroniser with fall detect, and baud_clk rising-edge tick
module uart_rx_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic rx_line,
  input  logic baud_clk,
  output logic line_s,
  output logic line_fall,
  output logic tick
);
  logic [2:0] line_q;
  logic       baud_q;
  logic       tick_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_q <= '1;
      baud_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      line_q <= {line_q[1:0], rx_line};
      baud_q <= baud_clk;
      tick_q <= baud_clk & ~baud_q;
    end
  end
  // line_q[2] only remembers the previous synchronised level for edge detection
  assign line_s    = line_q[1];
  assign line_fall = line_q[2] & ~line_q[1];
  assign tick      = tick_q;
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART RX deframer; parity stage compiled in by UART_RX_PARITY_EN
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 baud_clk,
  input  logic                 rx_line,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] MID  = TW'(mid_tick(OVERSAMPLE));
  localparam logic [TW-1:0] LAST = TW'(last_tick(OVERSAMPLE));
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  logic line_s, line_fall, tick, at_last;
  state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic done_q, done_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic podd_q, podd_d, pmis_q, pmis_d, perr_q, perr_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif
  uart_rx_sync u_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_line   (rx_line),
    .baud_clk  (baud_clk),
    .line_s    (line_s),
    .line_fall (line_fall),
    .tick      (tick)
  );
  assign at_last = tick && tcnt_q == LAST;
  always_comb begin
    state_d = state_q;
    tcnt_d  = (tick && state_q != IDLE) ? tcnt_q + TW'(1) : tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    podd_d  = podd_q;
    pmis_d  = pmis_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: if (line_fall) begin
        state_d = START;
        tcnt_d  = '0;
      end
      START: if (tick && tcnt_q == MID) begin
        state_d = line_s ? IDLE : DATA;
        tcnt_d  = '0;
        bcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
        podd_d  = line_s ? podd_q : parity_odd;
`endif
      end
      DATA: if (at_last) begin
        tcnt_d          = '0;
        shift_d[bcnt_q] = line_s;
        state_d         = (bcnt_q == BLAST) ? AFTER_DATA : DATA;
        bcnt_d          = (bcnt_q == BLAST) ? bcnt_q : bcnt_q + BW'(1);
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (at_last) begin
        tcnt_d  = '0;
        pmis_d  = ^shift_q ^ line_s ^ podd_q;
        state_d = STOP;
      end
`endif
      STOP: if (at_last) begin
        tcnt_d  = '0;
        data_d  = shift_q;
        ferr_d  = ~line_s;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
        perr_d  = pmis_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      podd_q  <= 1'b0;
      pmis_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      podd_q  <= podd_d;
      pmis_q  <= pmis_d;
      perr_q  <= perr_d;
`endif
    end
  end
  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed vector table plus corner sequences for uart_rx_frame
module tb_uart_rx_frame;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b1, baud_clk = 1'b0, rx_line = 1'b1, parity_odd = 1'b0;
  logic [7:0] rx_data;
  logic rx_done, frame_err, parity_err, rx_busy;
  int n_cmp = 0, n_bad = 0, busy_bad = 0, bc = 0;
  logic [7:0] got[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       podd;
    logic       pbit;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;
  vec_t vt[5];

  uart_rx_frame dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .baud_clk   (baud_clk),
    .rx_line    (rx_line),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #10 clock = ~clock;
  always @(posedge clock) begin
    bc       <= (bc == 26) ? 0 : bc + 1;
    baud_clk <= (bc == 26);
  end
  always @(negedge clock) if (rx_done) got.push_back(rx_data);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge baud_clk);
    @(negedge clock);
  endtask

  task automatic send_bit(input logic v);
    if (!rx_busy) busy_bad++;
    rx_line = v;
    ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    rx_line = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    logic [7:0] v;
    chk({nm, " done seen"}, 32'(got.size() > 0), 1);
    v = (got.size() > 0) ? got.pop_front() : 8'hxx;
    chk({nm, " data at done"}, 32'(v), 32'(exp));
  endtask

  initial begin
    vt[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[3] = '{8'h07, 1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1};
    vt[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};

    #3 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset rx_data", 32'(rx_data), 0);
    chk("reset rx_done", 32'(rx_done), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    chk("reset parity_err", 32'(parity_err), 0);
    chk("reset rx_busy", 32'(rx_busy), 0);
    reset_n = 1'b1;
    ticks(4);

    for (int k = 0; k < 5; k++) begin
      parity_odd = vt[k].podd;
      busy_bad = 0;
      send_frame(vt[k].d, vt[k].stop, vt[k].pbit);
      rx_line = 1'b1;
      ticks(4);
      chk($sformatf("vec%0d done count", k), 32'(got.size()), 1);
      got.delete();
      chk($sformatf("vec%0d rx_data", k), 32'(rx_data), 32'(vt[k].exp_d));
      chk($sformatf("vec%0d frame_err", k), 32'(frame_err), 32'(vt[k].exp_fe));
      chk($sformatf("vec%0d parity_err", k), 32'(parity_err), 32'(PAR_EN ? vt[k].exp_pe : 1'b0));
      chk($sformatf("vec%0d busy through frame", k), 32'(busy_bad), 0);
      chk($sformatf("vec%0d busy after", k), 32'(rx_busy), 0);
    end

    parity_odd = 1'b0;
    rx_line = 1'b0;
    ticks(4);
    rx_line = 1'b1;
    ticks(8);
    chk("false start busy", 32'(rx_busy), 0);
    chk("false start no done", 32'(got.size()), 0);
    chk("false start rx_data", 32'(rx_data), 32'h5A);

    send_frame(8'h3C, 1'b0, 1'b0);
    pop_chk("bad stop", 8'h3C);
    chk("bad stop frame_err", 32'(frame_err), 1);
    ticks(48);
    chk("break no retrigger", 32'(got.size()), 0);
    chk("break busy", 32'(rx_busy), 0);
    chk("break flag held", 32'(frame_err), 1);
    rx_line = 1'b1;
    ticks(16);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    rx_line = 1'b1;
    ticks(4);
    chk("b2b done count", 32'(got.size()), 2);
    pop_chk("b2b first", 8'h00);
    pop_chk("b2b second", 8'hFF);
    chk("b2b frame_err", 32'(frame_err), 0);
    chk("b2b parity_err", 32'(parity_err), 0);

    rx_line = 1'b0;
    ticks(16);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx_line = 1'b1;
    ticks(8);
    reset_n = 1'b0;
    #1;
    chk("midreset rx_data", 32'(rx_data), 0);
    chk("midreset rx_done", 32'(rx_done), 0);
    chk("midreset frame_err", 32'(frame_err), 0);
    chk("midreset parity_err", 32'(parity_err), 0);
    chk("midreset rx_busy", 32'(rx_busy), 0);
    @(negedge clock);
    reset_n = 1'b1;
    ticks(32);
    chk("midreset no done", 32'(got.size()), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    rx_line = 1'b1;
    ticks(4);
    pop_chk("after reset", 8'h81);
    chk("after reset rx_data", 32'(rx_data), 32'h81);
    chk("after reset frame_err", 32'(frame_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
